regfile_wb_arb: RTL and testbench
=================================

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 Parameter ASIZE, default 5, register address width.
REQ-002 Parameter DSIZE, default 32, register data width.
REQ-003 Parameter MAXWAIT, default 3, denied-cycle limit for the low-priority requester in fixed mode (1..15).
REQ-004 Parameter ZERO_PROTECT, default 1, 1 = writes to address 0 are consumed but never issued.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 en  input  1  arbitration enable; 0 = stall, no grants.
REQ-009 mode  input  1  0 = fixed priority (req0 first), 1 = round-robin.
REQ-010 req0_valid, req1_valid  input  1 each  requester has a write pending.
REQ-011 req0_addr, req1_addr  input  ASIZE each  destination register.
REQ-012 req0_data, req1_data  input  DSIZE each  write data.
REQ-013 req0_ready, req1_ready  output  1 each  grant; the transfer occurs when valid and ready are both 1 on a rising edge.
REQ-014 wen  output  1  registered write enable to the register file.
REQ-015 waddr  output  ASIZE  registered write address.
REQ-016 wdata  output  DSIZE  registered write data.
REQ-017 wsrc  output  1  registered index of the requester whose write is on wen/waddr/wdata.

Function
REQ-018 Ready outputs shall be combinational from the current inputs and state; at most one ready shall be high per cycle, and ready shall be high only when the matching valid is high, en=1 and rst=0.
REQ-019 Fixed mode: req0 shall win when both are valid, except when wait1 equals MAXWAIT, in which case req1 shall win.
REQ-020 Round-robin mode: when both are valid, the requester indicated by pointer rr shall win; after any grant, rr shall update to the index of the non-granted requester; rr shall hold when no grant occurs.
REQ-021 A lone valid requester shall be granted in the same cycle, in either mode.
REQ-022 wait1 (4-bit) shall increment, saturating at MAXWAIT, on each edge where req1_valid=1 and req1_ready=0 and en=1; it shall clear on a req1 grant and shall hold while en=0.
REQ-023 On the edge of a grant, wen shall be 1 and waddr/wdata/wsrc shall take the granted requester's values; latency from handshake to wen is exactly one cycle.
REQ-024 With no grant on an edge, wen shall be 0 and waddr/wdata/wsrc shall hold their previous values.
REQ-025 With ZERO_PROTECT=1 and granted address 0, the handshake shall complete, wen shall be 0, and waddr/wdata/wsrc shall still update.
REQ-026 When both requesters target the same address in the same cycle, only the winner shall be granted; the loser stays pending and is written in a later cycle, so the last write wins in grant order.
REQ-027 A mode change shall take effect in the same cycle; rr and wait1 shall be retained across mode changes.
REQ-028 en=0 shall force both ready outputs to 0, and wen shall be 0 on the next edge.

Reset
REQ-029 rst=1 shall immediately, without a clock, set wen=0, waddr=0, wdata=0, wsrc=0, rr=0 and wait1=0, and force both ready outputs to 0.
REQ-030 Reset asserted mid-transfer shall discard the in-flight write (wen=0); pending requests shall be arbitrated afresh after rst deasserts.
REQ-031 The first grant is possible on the first rising edge with rst=0.

Verification
REQ-032 Reset: pulse rst between edges while wen=1 -> wen=0, wsrc=0 and both ready=0 immediately, with no clock edge.
REQ-033 Fixed mode, both valid continuously (req0 addr 2 data 5, req1 addr 3 data 7), MAXWAIT=3 -> write sequence on wen: 2,2,2,3,2,2,2,3...
REQ-034 Round-robin mode, both valid continuously -> wsrc alternates 0,1,0,1 with wen=1 every cycle after the first grant.
REQ-035 req0 addr 0 data 9 with ZERO_PROTECT=1 -> req0_ready=1, next cycle wen=0 and waddr=0.
REQ-036 Both valid to addr 5 (req0 data 16, req1 data 2), fixed mode -> wdata 16 then 2 on consecutive cycles; final register value 2.
REQ-037 en=0 for 4 cycles with req1 valid -> ready=0 and wen=0 throughout, wait1 unchanged; req1 is granted on the first cycle with en=1.

Source files
------------

// File: rtl/regfile_wb_arb_if.sv
// Write-port bundle between two register-file writers and the arbiter.
// The arbiter presents the slave side; the requesters and the register file sit on the master side.
interface regfile_wb_arb_if #(
    parameter int ASIZE = 5,
    parameter int DSIZE = 32
);
    logic             en;
    logic             mode;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [ASIZE-1:0] req0_addr, req1_addr;
    logic [DSIZE-1:0] req0_data, req1_data;
    logic             wen;
    logic [ASIZE-1:0] waddr;
    logic [DSIZE-1:0] wdata;
    logic             wsrc;

    modport master (
        output en, mode, req0_valid, req1_valid, req0_addr, req1_addr, req0_data, req1_data,
        input  req0_ready, req1_ready, wen, waddr, wdata, wsrc
    );

    modport slave (
        input  en, mode, req0_valid, req1_valid, req0_addr, req1_addr, req0_data, req1_data,
        output req0_ready, req1_ready, wen, waddr, wdata, wsrc
    );
endinterface

// File: rtl/regfile_wb_arb.sv
// Two-requester write-back arbiter for a register file: fixed priority with starvation
// relief for req1, or round-robin, feeding one registered write port.
module regfile_wb_arb #(
    parameter int ASIZE        = 5,
    parameter int DSIZE        = 32,
    parameter int MAXWAIT      = 3,
    parameter int ZERO_PROTECT = 1
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_arb_if.slave    bus
);
    localparam logic [3:0] MW = 4'(MAXWAIT);

    logic [3:0]       wait1;
    logic             rr;
    logic             active, pick1, gnt0, gnt1, gnt;
    logic [ASIZE-1:0] gaddr;
    logic [DSIZE-1:0] gdata;

    // pick1 only matters when both are valid; a lone requester always wins
    assign active = bus.en & ~rst;
    assign pick1  = bus.mode ? rr : (wait1 == MW);
    assign gnt0   = active & bus.req0_valid & (~bus.req1_valid | ~pick1);
    assign gnt1   = active & bus.req1_valid & (~bus.req0_valid |  pick1);
    assign gnt    = gnt0 | gnt1;
    assign gaddr  = gnt1 ? bus.req1_addr : bus.req0_addr;
    assign gdata  = gnt1 ? bus.req1_data : bus.req0_data;

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wen   <= 1'b0;
            bus.waddr <= '0;
            bus.wdata <= '0;
            bus.wsrc  <= 1'b0;
            rr        <= 1'b0;
            wait1     <= '0;
        end else begin
            bus.wen <= 1'b0;
            if (gnt) begin
                // a write to r0 still consumes the request, it just never reaches the file
                bus.wen   <= !((ZERO_PROTECT != 0) && (gaddr == '0));
                bus.waddr <= gaddr;
                bus.wdata <= gdata;
                bus.wsrc  <= gnt1;
                rr        <= gnt0;
            end
            if (bus.en) begin
                if (gnt1)
                    wait1 <= '0;
                else if (bus.req1_valid && wait1 != MW)
                    wait1 <= wait1 + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb: expected writes are queued at issue time and a
// negedge monitor pops them whenever the write port fires.
module tb_regfile_wb_arb;
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        src;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    wr_t  q[$];

    always #5 clk = ~clk;

    regfile_wb_arb_if #(.ASIZE(5), .DSIZE(32)) bus ();

    regfile_wb_arb #(.ASIZE(5), .DSIZE(32), .MAXWAIT(3), .ZERO_PROTECT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [31:0] d, input logic s);
        wr_t w;
        w.addr = a; w.data = d; w.src = s;
        q.push_back(w);
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    endtask

    // check grants before the edge, then return 1 time unit after it
    task automatic step(input string name, input logic e0, input logic e1);
        #1;
        chk({name, "_ready0"}, 32'(bus.req0_ready), 32'(e0));
        chk({name, "_ready1"}, 32'(bus.req1_ready), 32'(e1));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.wen === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h src %0d expected none",
                         bus.waddr, bus.wdata, bus.wsrc);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr", 32'(bus.waddr), 32'(e.addr));
                chk("wr_data", bus.wdata, e.data);
                chk("wr_src", 32'(bus.wsrc), 32'(e.src));
            end
        end
    end

    initial begin
        bus.en = 1'b1;
        bus.mode = 1'b0;
        drive(1, 5'd2, 32'd5, 1, 5'd3, 32'd7);

        // reset state, with both requesters already asserting
        #3;
        chk("rst_wen", 32'(bus.wen), 0);
        chk("rst_waddr", 32'(bus.waddr), 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_wsrc", 32'(bus.wsrc), 0);
        chk("rst_ready0", 32'(bus.req0_ready), 0);
        chk("rst_ready1", 32'(bus.req1_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // fixed priority, MAXWAIT=3: 0,0,0,1,0,0,0,1
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 3) begin exp_wr(5'd3, 32'd7, 1'b1); step("fixed", 0, 1); end
            else            begin exp_wr(5'd2, 32'd5, 1'b0); step("fixed", 1, 0); end
        end

        // round-robin, rr=0 after the last req1 grant
        bus.mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin exp_wr(5'd2, 32'd5, 1'b0); step("rr", 1, 0); end
            else            begin exp_wr(5'd3, 32'd7, 1'b1); step("rr", 0, 1); end
        end

        // zero-protected write: consumed, not issued, register still updates
        bus.mode = 1'b0;
        drive(1, 5'd0, 32'd9, 0, 5'd0, 32'd0);
        step("zero", 1, 0);
        chk("zero_wen", 32'(bus.wen), 0);
        chk("zero_waddr", 32'(bus.waddr), 0);
        chk("zero_wdata", bus.wdata, 32'd9);
        chk("zero_wsrc", 32'(bus.wsrc), 0);

        // same-address collision: winner then loser, last write (2) lands
        drive(1, 5'd5, 32'd16, 1, 5'd5, 32'd2);
        exp_wr(5'd5, 32'd16, 1'b0);
        step("same", 1, 0);
        drive(0, 5'd5, 32'd16, 1, 5'd5, 32'd2);
        exp_wr(5'd5, 32'd2, 1'b1);
        step("same", 0, 1);

        // build wait1 to 2, stall 4 cycles, then the held count gives one more req0 grant
        drive(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB1);
        exp_wr(5'd10, 32'hA0, 1'b0); step("pre", 1, 0);
        exp_wr(5'd10, 32'hA0, 1'b0); step("pre", 1, 0);
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step("stall", 0, 0);
            chk("stall_wen", 32'(bus.wen), 0);
        end
        bus.en = 1'b1;
        exp_wr(5'd10, 32'hA0, 1'b0); step("resume", 1, 0);
        exp_wr(5'd11, 32'hB1, 1'b1); step("resume", 0, 1);

        // lone req1 through a stall is granted on the first enabled cycle
        drive(0, 5'd0, 32'd0, 1, 5'd12, 32'hC2);
        bus.en = 1'b0;
        step("stall1", 0, 0);
        chk("stall1_wen", 32'(bus.wen), 0);
        bus.en = 1'b1;
        exp_wr(5'd12, 32'hC2, 1'b1);
        step("lone1", 0, 1);

        // reset between edges discards the write already on the port
        drive(0, 5'd0, 32'd0, 1, 5'd4, 32'h44);
        step("inflight", 0, 1);
        chk("inflight_wen", 32'(bus.wen), 1);
        chk("inflight_wsrc", 32'(bus.wsrc), 1);
        void'(q.size());
        #1 rst = 1'b1;
        #1;
        chk("async_wen", 32'(bus.wen), 0);
        chk("async_wsrc", 32'(bus.wsrc), 0);
        chk("async_waddr", 32'(bus.waddr), 0);
        chk("async_wdata", bus.wdata, 0);
        chk("async_ready0", 32'(bus.req0_ready), 0);
        chk("async_ready1", 32'(bus.req1_ready), 0);
        rst = 1'b0;
        exp_wr(5'd4, 32'h44, 1'b1);
        step("after_rst", 0, 1);

        // drain and confirm every expected write was seen
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        step("idle", 0, 0);
        step("idle", 0, 0);
        chk("queue_empty", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
